// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and types used by the memories and pipeline registers.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int DMEM_DEPTH = 256;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/data_memory.sv
// MEM-stage data memory: word-addressed storage with a synchronous clear/write
// and a combinational, enable-gated read port.
module data_memory #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::DMEM_DEPTH,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] out,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data
);

    // DEPTH must be a power of two so that dropping the upper address bits
    // is exactly a modulo-(DEPTH*4) wrap.
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [IDX_W-1:0]  word_idx;

    // Byte offset bits and everything above the index are discarded here and
    // nowhere else, so alignment and wrap behaviour live in one place.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] byte_addr);
        return byte_addr[IDX_W+1:2];
    endfunction

    assign word_idx = word_index(addr);

    // The ignored address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[1:0], addr[ADDR_W-1:IDX_W+2]};

    // Clear takes priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[word_idx] <= wr_data;
        end
    end

    // Read shows the pre-edge contents; no bypass of a concurrent write.
    always_comb begin
        out = '0;
        if (rd_en) begin
            out = mem_reg[word_idx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
    import cpu_pkg::*;

    logic  clk;
    logic  rst;
    logic  [31:0] addr;
    logic  rd_en;
    word_t dout;
    logic  wr_en;
    word_t wr_data;

    int errors = 0;
    int checks = 0;

    data_memory dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .rd_en   (rd_en),
        .out     (dout),
        .wr_en   (wr_en),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp)
            $display("[%s] out=%h exp=%h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] a, input word_t d);
        addr = a; wr_data = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input word_t exp);
        addr = a; rd_en = 1'b1;
        #1;
        check(tag, dout, exp);
    endtask

    initial begin
        rst = 1'b1; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
        step();
        rst = 1'b0;
        step();

        // Cleared after reset
        read_check("rst_a0",    32'd0,    32'h0);
        read_check("rst_a4",    32'd4,    32'h0);
        read_check("rst_a1020", 32'd1020, 32'h0);
        rd_en = 1'b0; #1;
        check("rst_rd_off", dout, 32'h0);

        // Basic write then read, and read gating
        write_word(32'd0, 32'h3);
        read_check("wr0_rd", 32'd0, 32'h3);
        rd_en = 1'b0; #1;
        check("wr0_rd_off", dout, 32'h0);

        // Byte offset ignored, address wraps at 1024 bytes
        write_word(32'd8, 32'hDEADBEEF);
        read_check("align_a9",   32'd9,    32'hDEADBEEF);
        read_check("align_a10",  32'd10,   32'hDEADBEEF);
        read_check("align_a11",  32'd11,   32'hDEADBEEF);
        read_check("wrap_a1032", 32'd1032, 32'hDEADBEEF);
        read_check("nbr_a4",     32'd4,    32'h0);
        read_check("nbr_a12",    32'd12,   32'h0);
        read_check("keep_a0",    32'd0,    32'h3);

        // Read-during-write: old word before the edge, new word after
        write_word(32'd4, 32'h11);
        addr = 32'd4; rd_en = 1'b1; wr_en = 1'b1; wr_data = 32'h22;
        #1;
        check("rdw_before", dout, 32'h11);
        step();
        check("rdw_after", dout, 32'h22);
        wr_en = 1'b0;

        // wr_en=0 must not modify contents
        write_word(32'd12, 32'h55);
        addr = 32'd12; wr_data = 32'hFFFF; wr_en = 1'b0;
        step();
        read_check("wr_dis_a12", 32'd12, 32'h55);

        // Reset wins over a simultaneous write and clears everything
        addr = 32'd12; wr_data = 32'h77; wr_en = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; wr_en = 1'b0;
        read_check("rstpri_a12", 32'd12, 32'h0);
        read_check("rstclr_a0",  32'd0,  32'h0);
        read_check("rstclr_a4",  32'd4,  32'h0);
        read_check("rstclr_a8",  32'd8,  32'h0);

        // Full sweep; reads use varied byte offsets and wrapped aliases
        rd_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            write_word(32'(i * 4), 32'(i * 3));
        end
        for (int i = 0; i < 256; i++) begin
            read_check($sformatf("sweep_%0d", i),
                       32'(i * 4 + (i % 4) + 1024 * (i % 3)), 32'(i * 3));
        end
        rd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
